// File: rtl/ysyx_23060187_mem_arb.sv
// Two-requester (IFU/LSU) arbiter onto a single memory port, one transaction in flight,
// round-robin on ties, with a response timeout and a sticky flag for unexpected responses.
module ysyx_23060187_mem_arb #(
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        ifu_req_valid,
   input  logic [31:0] ifu_req_addr,
   output logic        ifu_req_ready,
   output logic        ifu_resp_valid,
   output logic [31:0] ifu_resp_data,

   input  logic        lsu_req_valid,
   input  logic [31:0] lsu_req_addr,
   input  logic        lsu_req_wen,
   input  logic [31:0] lsu_req_wdata,
   input  logic [3:0]  lsu_req_wmask,
   output logic        lsu_req_ready,
   output logic        lsu_resp_valid,
   output logic [31:0] lsu_resp_data,

   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_wen,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wmask,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,

   output logic        resp_err,
   output logic        spurious_resp
);

   localparam logic [1:0]  IDLE      = 2'd0;
   localparam logic [1:0]  ISSUE     = 2'd1;
   localparam logic [1:0]  WAIT_RESP = 2'd2;
   localparam logic        OWN_IFU   = 1'b0;
   localparam logic        OWN_LSU   = 1'b1;
   localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYC - 1);

   logic [1:0]  state;
   logic        owner;
   logic        last_grant;
   logic [15:0] wait_cnt;
   logic        ifu_win;
   logic        lsu_win;
   logic        timeout_hit;
   logic        finish;

   // On a tie the requester that did not win last time gets the port.
   always_comb begin
      ifu_win = 1'b0;
      lsu_win = 1'b0;
      if (state == IDLE) begin
         if (ifu_req_valid && lsu_req_valid) begin
            lsu_win = (last_grant == OWN_IFU);
            ifu_win = (last_grant == OWN_LSU);
         end else begin
            ifu_win = ifu_req_valid;
            lsu_win = lsu_req_valid;
         end
      end
   end

   assign ifu_req_ready = ifu_win;
   assign lsu_req_ready = lsu_win;
   assign mem_req_valid = (state == ISSUE);
   assign timeout_hit   = (wait_cnt == CNT_LAST);
   assign finish        = (state == WAIT_RESP) && (mem_resp_valid || timeout_hit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         owner      <= OWN_IFU;
         last_grant <= OWN_IFU;
         wait_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ifu_win || lsu_win) begin
                  owner      <= lsu_win;
                  last_grant <= lsu_win;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_req_ready) begin
                  wait_cnt <= '0;
                  state    <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               wait_cnt <= wait_cnt + 16'd1;
               if (finish) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // IFU requests are always reads, so their write fields are forced to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req_addr  <= '0;
         mem_req_wen   <= 1'b0;
         mem_req_wdata <= '0;
         mem_req_wmask <= '0;
      end else if (lsu_win) begin
         mem_req_addr  <= lsu_req_addr;
         mem_req_wen   <= lsu_req_wen;
         mem_req_wdata <= lsu_req_wdata;
         mem_req_wmask <= lsu_req_wmask;
      end else if (ifu_win) begin
         mem_req_addr  <= ifu_req_addr;
         mem_req_wen   <= 1'b0;
         mem_req_wdata <= '0;
         mem_req_wmask <= '0;
      end
   end

   // A real response beats a timeout landing in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         ifu_resp_data  <= '0;
         lsu_resp_data  <= '0;
         resp_err       <= 1'b0;
      end else begin
         ifu_resp_valid <= finish && (owner == OWN_IFU);
         lsu_resp_valid <= finish && (owner == OWN_LSU);
         resp_err       <= finish && !mem_resp_valid;
         if (finish && (owner == OWN_IFU)) begin
            ifu_resp_data <= mem_resp_valid ? mem_resp_data : 32'h0;
         end
         if (finish && (owner == OWN_LSU)) begin
            lsu_resp_data <= mem_resp_valid ? mem_resp_data : 32'h0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         spurious_resp <= 1'b0;
      end else if (mem_resp_valid && (state != WAIT_RESP)) begin
         spurious_resp <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ysyx_23060187_mem_arb.sv
// Bench for ysyx_23060187_mem_arb: a fixed vector table, randomized transactions checked
// against a transaction-level model, and hand sequences for spurious responses and reset.
module tb_ysyx_23060187_mem_arb;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid;
   logic [31:0] ifu_req_addr;
   logic        ifu_req_ready;
   logic        ifu_resp_valid;
   logic [31:0] ifu_resp_data;
   logic        lsu_req_valid;
   logic [31:0] lsu_req_addr;
   logic        lsu_req_wen;
   logic [31:0] lsu_req_wdata;
   logic [3:0]  lsu_req_wmask;
   logic        lsu_req_ready;
   logic        lsu_resp_valid;
   logic [31:0] lsu_resp_data;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_wen;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        resp_err;
   logic        spurious_resp;

   always #5 clk = ~clk;

   ysyx_23060187_mem_arb #(.TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
      .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
      .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
      .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .resp_err(resp_err), .spurious_resp(spurious_resp)
   );

   typedef struct {
      logic        iv;
      logic        lv;
      logic [31:0] ia;
      logic [31:0] la;
      logic        lwen;
      logic [31:0] lwdata;
      logic [3:0]  lwmask;
      int          d;
      int          r;
      logic [31:0] rdata;
      logic        e_ifu;
      logic        e_lsu;
   } vec_t;

   vec_t        vecs [10];
   int          n_total = 0;
   int          n_pass  = 0;
   logic        m_last;
   logic [31:0] m_ifu_data;
   logic [31:0] m_lsu_data;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic resetDut();
      rst            = 1'b0;
      ifu_req_valid  = 1'b0;
      ifu_req_addr   = '0;
      lsu_req_valid  = 1'b0;
      lsu_req_addr   = '0;
      lsu_req_wen    = 1'b0;
      lsu_req_wdata  = '0;
      lsu_req_wmask  = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      m_last         = 1'b0;
      m_ifu_data     = '0;
      m_lsu_data     = '0;
      @(posedge clk); @(posedge clk); #1;
      checkOutput("reset_flags", 32'({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid,
                                      lsu_resp_valid, resp_err, spurious_resp}), 32'h0);
      checkOutput("reset_mem_addr", mem_req_addr, 32'h0);
      checkOutput("reset_mem_fields", mem_req_wdata | 32'({mem_req_wen, mem_req_wmask}), 32'h0);
      checkOutput("reset_resp_data", ifu_resp_data | lsu_resp_data, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   // Runs one complete transaction starting in an idle cycle at posedge+1.
   task automatic applyStimulus(input logic iv, input logic lv, input logic [31:0] ia,
                                input logic [31:0] la, input logic lwen, input logic [31:0] lwdata,
                                input logic [3:0] lwmask, input int d, input int r,
                                input logic [31:0] rdata, input logic e_ifu, input logic e_lsu);
      logic        lsu_win;
      logic [31:0] ea, ed, exp_rd;
      logic        ew, exp_err;
      logic [3:0]  em;
      int          c;
      ifu_req_valid = iv;  ifu_req_addr = ia;
      lsu_req_valid = lv;  lsu_req_addr = la;
      lsu_req_wen = lwen;  lsu_req_wdata = lwdata;  lsu_req_wmask = lwmask;
      #4;
      checkOutput("ifu_req_ready", 32'(ifu_req_ready), 32'(e_ifu));
      checkOutput("lsu_req_ready", 32'(lsu_req_ready), 32'(e_lsu));
      lsu_win = e_lsu;
      ea = lsu_win ? la : ia;
      ew = lsu_win & lwen;
      ed = lsu_win ? lwdata : 32'h0;
      em = lsu_win ? lwmask : 4'h0;
      @(posedge clk); #1;
      if (lsu_win) lsu_req_valid = 1'b0;
      else ifu_req_valid = 1'b0;
      ifu_req_addr  = $urandom;
      lsu_req_addr  = $urandom;
      lsu_req_wdata = $urandom;
      lsu_req_wmask = 4'($urandom);
      lsu_req_wen   = ~lsu_req_wen;
      for (int k = 0; k <= d; k++) begin
         mem_req_ready = (k == d);
         #4;
         checkOutput("mem_req_valid", 32'(mem_req_valid), 32'h1);
         checkOutput("mem_req_addr", mem_req_addr, ea);
         checkOutput("mem_req_wen", 32'(mem_req_wen), 32'(ew));
         checkOutput("mem_req_wdata", mem_req_wdata, ed);
         checkOutput("mem_req_wmask", 32'(mem_req_wmask), 32'(em));
         checkOutput("ready_while_busy", 32'({ifu_req_ready, lsu_req_ready}), 32'h0);
         @(posedge clk); #1;
      end
      mem_req_ready = 1'b0;
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      c = (r < T) ? r : T - 1;
      for (int i = 0; i <= c; i++) begin
         mem_resp_valid = (i == r);
         mem_resp_data  = (i == r) ? rdata : $urandom;
         #4;
         checkOutput("mem_req_valid_wait", 32'(mem_req_valid), 32'h0);
         checkOutput("resp_valid_early", 32'({ifu_resp_valid, lsu_resp_valid}), 32'h0);
         @(posedge clk); #1;
      end
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
      exp_err = (r >= T);
      exp_rd  = exp_err ? 32'h0 : rdata;
      if (lsu_win) m_lsu_data = exp_rd;
      else m_ifu_data = exp_rd;
      #4;
      checkOutput("ifu_resp_valid", 32'(ifu_resp_valid), 32'(!lsu_win));
      checkOutput("lsu_resp_valid", 32'(lsu_resp_valid), 32'(lsu_win));
      checkOutput("ifu_resp_data", ifu_resp_data, m_ifu_data);
      checkOutput("lsu_resp_data", lsu_resp_data, m_lsu_data);
      checkOutput("resp_err", 32'(resp_err), 32'(exp_err));
      checkOutput("mem_req_addr_hold", mem_req_addr, ea);
      @(posedge clk); #5;
      checkOutput("resp_pulse_end", 32'({ifu_resp_valid, lsu_resp_valid, resp_err}), 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      // iv lv ia la lwen lwdata lwmask d r rdata e_ifu e_lsu
      vecs[0] = '{1'b1, 1'b1, 32'h8000_0000, 32'h8000_0040, 1'b1, 32'h1111_2222, 4'hF, 0, 0, 32'hAAAA_0001, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 1'b1, 32'h8000_0004, 32'h8000_0044, 1'b1, 32'h3333_4444, 4'h1, 1, 1, 32'hAAAA_0002, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 32'h8000_0008, 32'h8000_0048, 1'b0, 32'h5555_6666, 4'h2, 0, 2, 32'hAAAA_0003, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 1'b1, 32'h8000_000C, 32'h8000_004C, 1'b1, 32'h7777_8888, 4'h4, 2, 0, 32'hAAAA_0004, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         1'b0, 32'h0,         4'h0, 0, 0, 32'h0000_0413, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 32'h0,         32'h8000_0100, 1'b1, 32'hCAFE_F00D, 4'h3, 5, 2, 32'hBBBB_0001, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 32'h8000_0200, 32'h0,         1'b0, 32'h0,         4'h0, 0, 20, 32'hDEAD_BEEF, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 32'h8000_0300, 32'h8000_0304, 1'b1, 32'h0BAD_CAFE, 4'h8, 0, T - 1, 32'hCCCC_0001, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 1'b1, 32'h0,         32'h8000_0400, 1'b0, 32'h0,         4'h0, 1, T, 32'hCCCC_0002, 1'b0, 1'b1};
      vecs[9] = '{1'b1, 1'b1, 32'h8000_0500, 32'h8000_0504, 1'b1, 32'h1234_5678, 4'h5, 0, 3, 32'hCCCC_0003, 1'b1, 1'b0};

      resetDut();
      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].iv, vecs[v].lv, vecs[v].ia, vecs[v].la, vecs[v].lwen, vecs[v].lwdata,
                       vecs[v].lwmask, vecs[v].d, vecs[v].r, vecs[v].rdata, vecs[v].e_ifu, vecs[v].e_lsu);
      end
      m_last = 1'b0;

      for (int n = 0; n < 50; n++) begin
         logic [1:0] sel;
         logic       iv, lv, win_lsu;
         sel = 2'($urandom_range(1, 3));
         iv = sel[0];
         lv = sel[1];
         win_lsu = lv && (!iv || !m_last);
         applyStimulus(iv, lv, $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 10), $urandom, iv && !win_lsu, win_lsu);
         m_last = win_lsu;
      end
      #4;
      checkOutput("no_spurious_yet", 32'(spurious_resp), 32'h0);
      @(posedge clk); #1;

      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h5A5A_5A5A;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #4;
         checkOutput("idle_resp_ignored", 32'({ifu_resp_valid, lsu_resp_valid}), 32'h0);
         checkOutput("spurious_sticky", 32'(spurious_resp), 32'h1);
         checkOutput("idle_resp_data_hold", ifu_resp_data ^ lsu_resp_data, m_ifu_data ^ m_lsu_data);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1;
      checkOutput("spurious_async_clear", 32'(spurious_resp), 32'h0);
      resetDut();

      ifu_req_valid = 1'b1;
      ifu_req_addr  = 32'h8000_0800;
      #4;
      checkOutput("post_reset_grant", 32'(ifu_req_ready), 32'h1);
      @(posedge clk); #1;
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      #2;
      rst = 1'b0;
      #2;
      checkOutput("midtxn_reset_valid", 32'({mem_req_valid, ifu_resp_valid, lsu_resp_valid}), 32'h0);
      checkOutput("midtxn_reset_addr", mem_req_addr, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h1234_ABCD;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #4;
         checkOutput("abandoned_no_resp", 32'({ifu_resp_valid, lsu_resp_valid, resp_err}), 32'h0);
         checkOutput("abandoned_spurious", 32'(spurious_resp), 32'h1);
         @(posedge clk); #1;
      end
      checkOutput("abandoned_data", ifu_resp_data, 32'h0);

      ifu_req_valid = 1'b1;
      #2;
      ifu_req_valid = 1'b0;
      @(posedge clk); #1;
      #4;
      checkOutput("withdrawn_no_issue", 32'(mem_req_valid), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ysyx_23060187_mem_arb.md
YSYX_23060187_MEM_ARB -- requirements
Module: ysyx_23060187_mem_arb

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 1023, WAIT_RESP cycles before forced error completion (range 1..65535).
REQ-002 Port: clk  in  1  sole clock, rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-low reset.
REQ-004 Port: ifu_req_valid  in  1  fetch request; ifu_req_addr  in  32  fetch address.
REQ-005 Port: ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-006 Port: ifu_resp_valid  out  1  fetch response pulse; ifu_resp_data  out  32  fetch data.
REQ-007 Port: lsu_req_valid  in  1; lsu_req_addr  in  32; lsu_req_wen  in  1; lsu_req_wdata  in  32; lsu_req_wmask  in  4  data request.
REQ-008 Port: lsu_req_ready  out  1; lsu_resp_valid  out  1; lsu_resp_data  out  32  LSU handshake and response.
REQ-009 Port: mem_req_valid  out  1; mem_req_addr  out  32; mem_req_wen  out  1; mem_req_wdata  out  32; mem_req_wmask  out  4  shared memory request.
REQ-010 Port: mem_req_ready  in  1; mem_resp_valid  in  1; mem_resp_data  in  32  memory handshake and response.
REQ-011 Port: resp_err  out  1  pulse alongside a response completed by timeout.
REQ-012 Port: spurious_resp  out  1  sticky flag, mem_resp_valid seen outside WAIT_RESP.

Function
REQ-013 States SHALL be IDLE, ISSUE, WAIT_RESP; one transaction outstanding at a time.
REQ-014 IDLE: if any req_valid, winner's req_ready SHALL be 1 combinationally that cycle; loser's req_ready 0.
REQ-015 Single requester SHALL win; tie SHALL go to the requester not equal to last_grant (round-robin).
REQ-016 On acceptance edge: latch addr/wen/wdata/wmask (IFU: wen=0, wdata=0, wmask=0), record owner, update last_grant, go ISSUE.
REQ-017 ISSUE: mem_req_valid=1 driving latched fields, stable until mem_req_ready=1; then WAIT_RESP and clear timeout counter.
REQ-018 Outside ISSUE, mem_req_valid SHALL be 0 and mem_req_* fields SHALL hold last latched values.
REQ-019 WAIT_RESP: counter increments per cycle; mem_resp_valid=1 SHALL register data to owner's resp_data and pulse owner's resp_valid for exactly one cycle next cycle; go IDLE.
REQ-020 WAIT_RESP: counter reaching TIMEOUT_CYC without response SHALL pulse owner's resp_valid with resp_data=32'h0 and resp_err=1 next cycle; go IDLE.
REQ-021 mem_resp_valid and timeout in same cycle: response wins, resp_err=0.
REQ-022 mem_resp_valid in IDLE or ISSUE SHALL be ignored for routing and SHALL set spurious_resp until reset.
REQ-023 Non-owner resp_valid SHALL stay 0; resp_data SHALL hold its last value between pulses.
REQ-024 Minimum latency: accept cycle N, mem_req_valid N+1, mem_resp_valid N+2 -> resp_valid N+3; next acceptance earliest N+3 (IDLE re-entered at N+3).
REQ-025 Requests withdrawn before acceptance SHALL cause no state change; no request is dropped once ready was given.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, last_grant=IFU (first tie to LSU), counter=0, all outputs 0 including spurious_resp.
REQ-027 rst asserted mid-transaction SHALL abandon it silently: no resp_valid pulse after release, first post-reset cycle in IDLE.
REQ-028 Reset release SHALL take effect on the first rising clk edge with rst=1.

Verification
REQ-029 IFU-only read addr 0x8000_0000, mem_req_ready=1, response 0x0000_0413 next cycle -> ifu_resp_valid one pulse at N+3 with data 0x0000_0413, lsu_resp_valid never 1.
REQ-030 Simultaneous IFU and LSU requests from reset, held -> grants LSU, IFU, LSU, IFU in order; each mem_req_wen matches owner.
REQ-031 LSU write addr 0x8000_0100, wdata 0xCAFE_F00D, wmask 4'b0011, mem_req_ready low 5 cycles -> mem_req_* stable 6 cycles, fields exact.
REQ-032 TIMEOUT_CYC=8, memory never responds -> owner resp_valid and resp_err pulse together, data 0, state returns to IDLE.
REQ-033 mem_resp_valid pulsed in IDLE -> no resp_valid, spurious_resp=1 held until rst=0.
REQ-034 rst=0 during WAIT_RESP, then response arrives after release -> no resp_valid, spurious_resp=1.
